// File: rtl/uart_tx_core.sv
// uart_tx_core: byte-wide transmit FIFO feeding an 8N1 UART serialiser.
// The bit period is (baud_div + 1) clk cycles; baud_div is captured at the
// start of every frame so that mid-frame changes only affect later frames.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between the
// last data bit and the stop bit (11-bit frame instead of 10).
module uart_tx_core #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx_irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]     CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  // Serialiser states; PARITY only exists in the parity build.
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
  } state_t;
`endif

  // ---------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             overflow_reg;
  logic [7:0]       head_data;
  logic             push;
  logic             pop;
  logic             drop;

  // ---------------------------------------------------------------------
  // Serialiser state
  // ---------------------------------------------------------------------
  state_t                 state_reg;
  state_t                 state_next;
  logic [DIV_WIDTH-1:0]   div_cnt_reg;
  logic [DIV_WIDTH-1:0]   div_cnt_next;
  logic [DIV_WIDTH-1:0]   div_latch_reg;
  logic [DIV_WIDTH-1:0]   div_latch_next;
  logic [2:0]             bit_cnt_reg;
  logic [2:0]             bit_cnt_next;
  logic [7:0]             shift_reg;
  logic [7:0]             shift_next;
  logic                   tx_reg;
  logic                   tx_next;
  logic                   bit_done;
`ifdef UART_TX_PARITY_EN
  logic                   parity_reg;
  logic                   parity_next;
`endif

  // Occupancy flags come from the registered count only, so a byte written
  // into an empty FIFO can never be popped in the same cycle.
  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);
  assign level = count_reg;

  // A write at full is still accepted when the serialiser pops that cycle.
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  // The head entry feeds the shift register directly on a pop.
  assign head_data = mem[rd_ptr_reg];

  // FIFO storage: write-only port, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Occupancy bookkeeping for the push/pop combinations.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointers and count; reset also flushes anything still queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
    end
  end

  // Sticky overflow: a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  // Last cycle of the current bit period, measured against the divisor
  // captured at frame start.
  assign bit_done = (div_cnt_reg == div_latch_reg);

  // Next-state logic; pops happen only in IDLE or on the final STOP cycle.
  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    div_latch_next = div_latch_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    pop            = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next    = parity_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop            = 1'b1;
          shift_next     = head_data;
          div_latch_next = baud_div;
          div_cnt_next   = '0;
          bit_cnt_next   = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_next    = ^head_data;
`endif
          state_next     = ST_START;
        end
      end

      ST_START: begin
        if (bit_done) begin
          div_cnt_next = '0;
          bit_cnt_next = 3'd0;
          state_next   = ST_DATA;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_ONE;
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          div_cnt_next = '0;
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next   = ST_PARITY;
`else
            state_next   = ST_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_ONE;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          div_cnt_next = '0;
          state_next   = ST_STOP;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_ONE;
        end
      end
`endif

      ST_STOP: begin
        if (bit_done) begin
          div_cnt_next = '0;
          if (!empty) begin
            // Back-to-back frame: no idle cycle between STOP and START.
            pop            = 1'b1;
            shift_next     = head_data;
            div_latch_next = baud_div;
            bit_cnt_next   = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_next    = ^head_data;
`endif
            state_next     = ST_START;
          end else begin
            state_next     = ST_IDLE;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the next state so that the
  // registered output lines up exactly with the state register.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  // Serialiser registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      div_cnt_reg   <= '0;
      div_latch_reg <= '0;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      tx_reg        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      div_latch_reg <= div_latch_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  assign tx     = tx_reg;
  assign busy   = (state_reg != ST_IDLE);
  assign tx_irq = empty && !busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed testbench for uart_tx_core (FIFO_DEPTH=8, DIV_WIDTH=16).
// Honours UART_TX_PARITY_EN: expected frames grow to 11 bits when defined.
module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        ovf_clr;
  logic        tx;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        busy;
  logic        overflow;
  logic        tx_irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_tx_core #(
    .FIFO_DEPTH(8),
    .DIV_WIDTH (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .baud_div(baud_div),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .ovf_clr (ovf_clr),
    .tx      (tx),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .busy    (busy),
    .overflow(overflow),
    .tx_irq  (tx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks tx and busy on every cycle of nframes consecutive frames, starting
  // at the current negedge (which must be the first START cycle).
  task automatic check_stream(input int nframes, input int baud);
    logic [7:0] b;
    for (int f = 0; f < nframes; f++) begin
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      for (int k = 0; k < FB; k++) begin
        for (int c = 0; c <= baud; c++) begin
          if (!(f == 0 && k == 0 && c == 0)) @(negedge clk);
          check($sformatf("byte%02h slot%0d cyc%0d tx", b, k, c), 32'(tx), 32'(exp_bit(b, k)));
          check($sformatf("byte%02h slot%0d cyc%0d busy", b, k, c), 32'(busy), 32'd1);
        end
      end
      $display("frame byte=%02h baud_div=%0d checked", b, baud);
    end
  endtask

  initial begin
    reset    = 1'b1;
    baud_div = 16'd0;
    wr_data  = 8'd0;
    wr_en    = 1'b0;
    ovf_clr  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst tx", 32'(tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst level", 32'(level), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst tx_irq", 32'(tx_irq), 32'd1);
    reset = 1'b0;
    $display("reset checked");

    // Single frame 0x55 at baud_div=3
    @(negedge clk);
    baud_div = 16'd3; wr_data = 8'h55; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("t1 level", 32'(level), 32'd1);
    check("t1 empty", 32'(empty), 32'd0);
    check("t1 tx idle", 32'(tx), 32'd1);
    check("t1 busy pre", 32'(busy), 32'd0);
    check("t1 tx_irq pre", 32'(tx_irq), 32'd0);
    @(negedge clk);
    exp_q.push_back(8'h55);
    check_stream(1, 3);
    @(negedge clk);
    check("t1 busy post", 32'(busy), 32'd0);
    check("t1 tx post", 32'(tx), 32'd1);
    check("t1 tx_irq post", 32'(tx_irq), 32'd1);

    // Back-to-back 0xA5, 0x3C at baud_div=0
    @(negedge clk);
    baud_div = 16'd0; wr_data = 8'hA5; wr_en = 1'b1;
    @(negedge clk);
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check_stream(2, 0);
    @(negedge clk);
    check("t2 busy post", 32'(busy), 32'd0);
    check("t2 tx_irq post", 32'(tx_irq), 32'd1);

    // Overflow at baud_div=7: ten writes in consecutive cycles
    @(negedge clk);
    baud_div = 16'd7; wr_data = 8'h10; wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    check("t3 level full", 32'(level), 32'd8);
    check("t3 full", 32'(full), 32'd1);
    check("t3 ovf before drop", 32'(overflow), 32'd0);
    wr_data = 8'h19; ovf_clr = 1'b1;   // drop coincides with clear
    @(negedge clk);
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("t3 ovf drop+clr", 32'(overflow), 32'd1);
    check("t3 level after drop", 32'(level), 32'd8);
    @(negedge clk);
    check("t3 ovf sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3 ovf cleared", 32'(overflow), 32'd0);
    $display("overflow set/clear checked");

    // Write coincident with the pop at end of the first frame while full
    repeat (FB * 8 - 11) @(negedge clk);
    check("t4 tx stop", 32'(tx), 32'd1);
    check("t4 full pre", 32'(full), 32'd1);
    wr_data = 8'hEE; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("t4 level stays", 32'(level), 32'd8);
    check("t4 ovf stays 0", 32'(overflow), 32'd0);
    check("t4 full stays", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'hEE);
    check_stream(9, 7);
    @(negedge clk);
    check("t4 busy post", 32'(busy), 32'd0);
    check("t4 empty post", 32'(empty), 32'd1);
    check("t4 tx_irq post", 32'(tx_irq), 32'd1);

    // Reset during data bit 3 of 0xF0 with 0x0F still queued
    @(negedge clk);
    baud_div = 16'd3; wr_data = 8'hF0; wr_en = 1'b1;
    @(negedge clk);
    wr_data = 8'h0F;
    @(negedge clk);
    wr_en = 1'b0;
    check("t5 start tx", 32'(tx), 32'd0);
    check("t5 level", 32'(level), 32'd1);
    repeat (16) @(negedge clk);
    check("t5 bit3 tx", 32'(tx), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5 rst tx", 32'(tx), 32'd1);
    check("t5 rst level", 32'(level), 32'd0);
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst empty", 32'(empty), 32'd1);
    check("t5 rst tx_irq", 32'(tx_irq), 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("t5 quiet%0d tx", i), 32'(tx), 32'd1);
      check($sformatf("t5 quiet%0d busy", i), 32'(busy), 32'd0);
    end
    $display("mid-frame reset checked");

    // 0x07 at baud_div=1: parity slot (if built in) then STOP
    @(negedge clk);
    baud_div = 16'd1; wr_data = 8'h07; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h07);
    check_stream(1, 1);
    @(negedge clk);
    check("t6 busy post", 32'(busy), 32'd0);
    check("t6 tx post", 32'(tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, baud divisor width.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_div  input  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port wr_en  input  1  enqueue strobe, one byte per cycle.
REQ-008 SHALL have port ovf_clr  input  1  clears overflow flag.
REQ-009 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-010 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port empty  output  1  FIFO holds zero bytes.
REQ-012 SHALL have port level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port busy  output  1  FSM not in IDLE.
REQ-014 SHALL have port overflow  output  1  sticky, a write was dropped.
REQ-015 SHALL have port tx_irq  output  1  level interrupt to the interrupt controller, = empty AND NOT busy.

Function
REQ-016 FIFO SHALL accept wr_data when wr_en=1 and full=0; write with full=1 and no same-cycle pop SHALL be dropped and set overflow.
REQ-017 Simultaneous write and pop SHALL both occur; level unchanged, including at full (write accepted, no overflow).
REQ-018 Pop SHALL only occur from registered non-empty state; write into empty FIFO is never popped in the same cycle.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: tx=1; when empty=0, pop head into shift register, latch baud_div, go START; tx low on the following cycle.
REQ-021 Each bit (START, each DATA bit, PARITY, STOP) SHALL last exactly latched baud_div+1 clk cycles; baud_div=0 gives one cycle per bit.
REQ-022 START drives tx=0; DATA drives 8 bits LSB first; STOP drives tx=1 for one bit period.
REQ-023 At end of STOP: if empty=0 pop and go directly to START (no idle gap); else go IDLE.
REQ-024 baud_div changes mid-frame SHALL not affect the current frame; new value used from next START.
REQ-025 Bit counter SHALL count 0..7 and wrap with no extra cycle; divisor counter SHALL reload on every bit boundary.
REQ-026 overflow SHALL stay set until ovf_clr=1; ovf_clr and a new drop in the same cycle SHALL leave overflow set.

Reset
REQ-027 On reset: tx=1, state IDLE, busy=0, level=0, empty=1, full=0, overflow=0, tx_irq=1, counters zero.
REQ-028 Reset mid-frame SHALL abort the frame, flush the FIFO and drive tx=1 from the next cycle.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, tx = XOR of the 8 data bits (even parity), frame 11 bit periods.
REQ-030 Macro undefined: PARITY state absent, DATA goes directly to STOP, frame 10 bit periods.

Verification
REQ-031 Reset, baud_div=3, write 0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; busy high 40 cycles; tx_irq returns to 1.
REQ-032 baud_div=0, write 0xA5,0x3C back-to-back -> 20 consecutive bit cycles, second START immediately after first STOP, no idle cycle.
REQ-033 baud_div=7, write 10 bytes in consecutive cycles with FIFO_DEPTH=8 -> full=1 after the first pop, excess bytes dropped, overflow=1; ovf_clr clears it.
REQ-034 Full FIFO, wr_en coincident with pop -> level stays 8, overflow stays 0, written byte transmitted last.
REQ-035 Reset asserted during bit 3 of a frame -> tx=1 next cycle, level=0, busy=0, no further activity.
REQ-036 With UART_TX_PARITY_EN, baud_div=1, write 0x07 -> parity bit 1 between bit 7 and STOP; without macro, no parity bit.
